// File: rtl/usb_tx_nrzi_encoder.sv
// Full-speed USB packet transmitter: SYNC, payload with bit stuffing, NRZI line coding and EOP,
// advancing one bit time per shift strobe.
module usb_tx_nrzi_encoder #(
  parameter int unsigned MAX_BYTES = 11,
  parameter int unsigned SYNC_BITS = 8,
  parameter int unsigned EOP_SE0   = 2,
  localparam int unsigned LEN_W    = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   shift,
  input  logic                   tx_start,
  input  logic [LEN_W-1:0]       tx_len,
  input  logic [8*MAX_BYTES-1:0] tx_data,
  output logic [1:0]             d_out,
  output logic                   tx_busy,
  output logic                   tx_done,
  output logic                   tx_err
);

  localparam int unsigned BIT_W  = $clog2(8 * MAX_BYTES);
  localparam int unsigned SYNC_W = $clog2(SYNC_BITS + 1);
  localparam int unsigned EOP_W  = $clog2(EOP_SE0 + 1);
  localparam logic [1:0]  LineJ   = 2'b10;
  localparam logic [1:0]  LineSe0 = 2'b00;

  typedef enum logic [2:0] {
    StIdle, StArmed, StSync, StPayload, StStuff, StEopSe0, StEopJ
  } state_e;

  state_e                 state_q;
  logic [8*MAX_BYTES-1:0] data_q;
  logic [LEN_W-1:0]       len_q;
  logic [BIT_W-1:0]       bit_idx_q;
  logic [2:0]             ones_q;
  logic [SYNC_W-1:0]      sync_cnt_q;
  logic [EOP_W-1:0]       eop_cnt_q;
  logic                   last_q;

  logic             len_ok;
  logic             sync_raw;
  logic             pay_raw;
  logic             pay_last;
  logic [2:0]       pay_ones;
  logic [LEN_W+2:0] len_bits;
  logic [BIT_W-1:0] last_idx;

  always_comb begin
    len_ok   = (tx_len != '0) && (tx_len <= LEN_W'(MAX_BYTES));
    // SYNC is all zeros except its final bit
    sync_raw = (sync_cnt_q == SYNC_W'(SYNC_BITS - 1));
    len_bits = {len_q, 3'b000} - {{(LEN_W + 2){1'b0}}, 1'b1};
    last_idx = BIT_W'(len_bits);
    pay_raw  = data_q[bit_idx_q];
    pay_last = (bit_idx_q == last_idx);
    pay_ones = pay_raw ? (ones_q + 3'd1) : 3'd0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= StIdle;
      d_out      <= LineJ;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_err     <= 1'b0;
      data_q     <= '0;
      len_q      <= '0;
      bit_idx_q  <= '0;
      ones_q     <= '0;
      sync_cnt_q <= '0;
      eop_cnt_q  <= '0;
      last_q     <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (tx_start) begin
            if (len_ok) begin
              data_q     <= tx_data;
              len_q      <= tx_len;
              bit_idx_q  <= '0;
              sync_cnt_q <= '0;
              eop_cnt_q  <= '0;
              last_q     <= 1'b0;
              tx_busy    <= 1'b1;
              state_q    <= StArmed;
            end else begin
              tx_err <= 1'b1;
            end
          end
        end
        StArmed, StSync: begin
          if (shift) begin
            d_out  <= sync_raw ? d_out : ~d_out;
            ones_q <= sync_raw ? 3'd1 : 3'd0;
            if (sync_raw) begin
              sync_cnt_q <= '0;
              state_q    <= StPayload;
            end else begin
              sync_cnt_q <= sync_cnt_q + SYNC_W'(1);
              state_q    <= StSync;
            end
          end
        end
        StPayload: begin
          if (shift) begin
            d_out  <= pay_raw ? d_out : ~d_out;
            ones_q <= pay_ones;
            last_q <= pay_last;
            if (!pay_last) bit_idx_q <= bit_idx_q + BIT_W'(1);
            if (pay_ones == 3'd6) state_q <= StStuff;
            else if (pay_last)    state_q <= StEopSe0;
          end
        end
        StStuff: begin
          if (shift) begin
            d_out   <= ~d_out;
            ones_q  <= '0;
            state_q <= last_q ? StEopSe0 : StPayload;
          end
        end
        StEopSe0: begin
          if (shift) begin
            d_out <= LineSe0;
            if (eop_cnt_q == EOP_W'(EOP_SE0 - 1)) begin
              eop_cnt_q <= '0;
              state_q   <= StEopJ;
            end else begin
              eop_cnt_q <= eop_cnt_q + EOP_W'(1);
            end
          end
        end
        StEopJ: begin
          if (shift) begin
            d_out   <= LineJ;
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_nrzi_encoder.sv
// Self-checking bench for usb_tx_nrzi_encoder against a line-symbol model built from the
// packet rules (SYNC, stuffing, NRZI, EOP).
module tb_usb_tx_nrzi_encoder;

  localparam logic [1:0] J = 2'b10;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        shift = 1'b0;
  logic        tx_start = 1'b0;
  logic [3:0]  tx_len = '0;
  logic [87:0] tx_data = '0;
  logic [1:0]  d_out;
  logic        tx_busy, tx_done, tx_err;

  int checks = 0;
  int failures = 0;
  logic [1:0] exp_q[$];

  usb_tx_nrzi_encoder dut (
    .clk(clk), .n_rst(n_rst), .shift(shift), .tx_start(tx_start), .tx_len(tx_len),
    .tx_data(tx_data), .d_out(d_out), .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  function automatic logic [87:0] rand88();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[87:0];
  endfunction

  // Expected line symbol for every strobe of a packet.
  task automatic build_model(input int len, input logic [87:0] data);
    bit raw[$];
    int ones;
    logic [1:0] lvl;
    exp_q.delete();
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      raw.push_back(i == 7);
      ones = (i == 7) ? ones + 1 : 0;
    end
    for (int i = 0; i < 8 * len; i++) begin
      raw.push_back(data[i]);
      ones = data[i] ? ones + 1 : 0;
      if (ones == 6) begin
        raw.push_back(1'b0);
        ones = 0;
      end
    end
    lvl = J;
    foreach (raw[i]) begin
      if (!raw[i]) lvl = ~lvl;
      exp_q.push_back(lvl);
    end
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b00);
    exp_q.push_back(J);
  endtask

  // Caller is at a negedge; request is sampled on the next posedge.
  task automatic start_req(input int len, input logic [87:0] data);
    tx_start = 1'b1;
    tx_len   = 4'(len);
    tx_data  = data;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = rand88();
    tx_len   = 4'($urandom);
    checks++;
    if (tx_busy !== 1'b1 || tx_err !== 1'b0 || d_out !== J) begin
      failures++;
      $display("FAIL accept: busy=%b err=%b d_out=%b, want busy=1 err=0 d_out=10",
               tx_busy, tx_err, d_out);
    end
  endtask

  // Strobes until tx_done (bounded), comparing each symbol with exp_q.
  task automatic run_packet(input int mingap, input int maxgap, input int stall_at,
                            input bit poke, output int n);
    bit done_seen;
    int gap;
    logic [1:0] prev;
    n = 0;
    done_seen = 0;
    while (!done_seen && n < exp_q.size() + 4) begin
      gap = (n == stall_at) ? 10 : int'($urandom_range(maxgap, mingap));
      prev = d_out;
      for (int g = 0; g < gap; g++) begin
        if (poke) begin
          tx_start = $urandom_range(1, 0) == 1;
          tx_len   = 4'($urandom_range(11, 1));
          tx_data  = rand88();
        end
        @(negedge clk);
        checks++;
        if (d_out !== prev || tx_err !== 1'b0) begin
          failures++;
          $display("FAIL hold strobe %0d: d_out=%b err=%b, want d_out=%b err=0",
                   n, d_out, tx_err, prev);
        end
      end
      tx_start = 1'b0;
      shift = 1'b1;
      @(negedge clk);
      shift = 1'b0;
      checks++;
      if (n >= exp_q.size()) begin
        failures++;
        $display("FAIL extra strobe %0d: d_out=%b, want tx_done by now", n, d_out);
      end else if (d_out !== exp_q[n] ||
                   tx_done !== (n == exp_q.size() - 1) ||
                   tx_busy !== (n != exp_q.size() - 1)) begin
        failures++;
        $display("FAIL strobe %0d: d_out=%b done=%b busy=%b, want d_out=%b done=%b busy=%b",
                 n, d_out, tx_done, tx_busy, exp_q[n], n == exp_q.size() - 1,
                 n != exp_q.size() - 1);
      end
      done_seen = tx_done;
      n++;
    end
    checks++;
    if (n != exp_q.size()) begin
      failures++;
      $display("FAIL strobe count: got %0d, want %0d", n, exp_q.size());
    end
  endtask

  task automatic check_done_cleared();
    @(negedge clk);
    checks++;
    if (tx_done !== 1'b0 || tx_busy !== 1'b0 || d_out !== J) begin
      failures++;
      $display("FAIL post-done: done=%b busy=%b d_out=%b, want 0 0 10", tx_done, tx_busy, d_out);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (d_out !== J || tx_busy !== 1'b0 || tx_done !== 1'b0 || tx_err !== 1'b0) begin
      failures++;
      $display("FAIL reset: d_out=%b busy=%b done=%b err=%b, want 10 0 0 0",
               d_out, tx_busy, tx_done, tx_err);
    end
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fixed(input string name, input int len, input logic [87:0] data,
                            input int want_strobes, input int gap);
    int n;
    build_model(len, data);
    start_req(len, data);
    run_packet(gap, gap, -1, 1'b0, n);
    checks++;
    if (n != want_strobes) begin
      failures++;
      $display("FAIL %s length: got %0d strobes, want %0d", name, n, want_strobes);
    end
    check_done_cleared();
  endtask

  task automatic test_reject(input int len);
    tx_start = 1'b1;
    tx_len   = 4'(len);
    tx_data  = rand88();
    @(negedge clk);
    tx_start = 1'b0;
    checks++;
    if (tx_err !== 1'b1 || tx_busy !== 1'b0 || d_out !== J) begin
      failures++;
      $display("FAIL reject len %0d: err=%b busy=%b d_out=%b, want 1 0 10",
               len, tx_err, tx_busy, d_out);
    end
    shift = 1'b1;
    @(negedge clk);
    shift = 1'b0;
    checks++;
    if (tx_err !== 1'b0 || tx_busy !== 1'b0 || d_out !== J) begin
      failures++;
      $display("FAIL reject len %0d after: err=%b busy=%b d_out=%b, want 0 0 10",
               len, tx_err, tx_busy, d_out);
    end
  endtask

  task automatic test_gap();
    int n;
    logic [87:0] d;
    d = rand88();
    build_model(2, d);
    start_req(2, d);
    run_packet(0, 1, 12, 1'b0, n);
    check_done_cleared();
  endtask

  task automatic test_reset_mid();
    logic [87:0] d;
    int n;
    d = rand88();
    build_model(3, d);
    start_req(3, d);
    for (int i = 0; i < 12; i++) begin
      shift = 1'b1;
      @(negedge clk);
      shift = 1'b0;
      checks++;
      if (d_out !== exp_q[i]) begin
        failures++;
        $display("FAIL pre-reset strobe %0d: d_out=%b, want %b", i, d_out, exp_q[i]);
      end
    end
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if (d_out !== J || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      failures++;
      $display("FAIL async reset: d_out=%b busy=%b done=%b, want 10 0 0", d_out, tx_busy, tx_done);
    end
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      shift = 1'b1;
      @(negedge clk);
      shift = 1'b0;
      checks++;
      if (d_out !== J || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
        failures++;
        $display("FAIL idle after reset: d_out=%b busy=%b done=%b, want 10 0 0",
                 d_out, tx_busy, tx_done);
      end
    end
    d = rand88();
    build_model(1, d);
    start_req(1, d);
    run_packet(0, 2, -1, 1'b0, n);
    check_done_cleared();
  endtask

  // Random packets chained back to back, with tx_start noise while busy.
  task automatic test_back_to_back();
    int n, len;
    logic [87:0] d;
    len = int'($urandom_range(11, 1));
    d = rand88();
    build_model(len, d);
    start_req(len, d);
    for (int p = 0; p < 6; p++) begin
      run_packet(0, 2, -1, 1'b1, n);
      len = int'($urandom_range(11, 1));
      d = rand88();
      for (int b = 0; b < 11; b++) if ($urandom_range(1, 0) == 1) d[8*b +: 8] = 8'hFF;
      build_model(len, d);
      start_req(len, d);
    end
    run_packet(0, 2, -1, 1'b1, n);
    check_done_cleared();
  endtask

  initial begin
    test_reset();
    test_fixed("ack", 1, 88'hD2, 19, 3);
    test_fixed("stuff", 1, 88'hFF, 20, 1);
    test_fixed("max", 11, 88'h0, 99, 0);
    test_reject(0);
    test_reject(12);
    test_gap();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
